spi_pkt_decoder: RTL and testbench

SPI_PKT_DECODER -- requirements
Module: spi_pkt_decoder

---
 rtl/spi_pkt_decoder.sv | 127 ++++++++++++
 tb/tb_spi_pkt_decoder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/spi_pkt_decoder.sv
// spi_pkt_decoder: decodes SPI messages into register-file writes (streamed write or fill).
// Define SPI_PKT_CHECKSUM_EN to require a trailing XOR checksum byte per message.
module spi_pkt_decoder #(
    parameter logic [7:0] OP_WRITE = 8'h01,
    parameter logic [7:0] OP_FILL  = 8'h02
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_end,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       pkt_ok,
    output logic       pkt_err
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CNT, S_VAL, S_FILL, S_DROP} state_t;
    state_t     r_state;
    logic [7:0] r_ptr, r_val;
    logic [8:0] r_cnt;
    logic       r_fill, r_err, r_hdr, r_end;
    logic       w_op_ok, w_fill_err, w_ck_bad, w_hdr, w_done, w_bad;
`ifdef SPI_PKT_CHECKSUM_EN
    logic [7:0] r_x, w_x;
    logic       r_ck;
    assign w_x        = r_x ^ (rx_valid ? rx_data : 8'h00);
    assign w_ck_bad   = |w_x;
    // the first byte arriving during a fill is that message's checksum, not an error
    assign w_fill_err = rx_valid & r_ck;
`else
    assign w_ck_bad   = 1'b0;
    assign w_fill_err = rx_valid;
`endif
    assign w_op_ok = (rx_data == OP_WRITE) || (rx_data == OP_FILL);
    assign w_hdr   = (r_state != S_IDLE) && (r_hdr || (r_state == S_ADDR && rx_valid && !r_fill));
    assign w_bad   = r_err || (r_state == S_FILL && w_fill_err) || !w_hdr || w_ck_bad;
    // a fill defers end-of-message until its last write has been presented
    assign w_done  = r_state == S_FILL ? (r_cnt == 9'd0 && (r_end || rx_end))
                   : r_state == S_VAL  ? (rx_end && !rx_valid)
                   : r_state == S_IDLE ? (rx_end && rx_valid)
                   : rx_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= 8'h00;
            r_val   <= 8'h00;
            r_cnt   <= 9'd0;
            r_fill  <= 1'b0;
            r_err   <= 1'b0;
            r_hdr   <= 1'b0;
            r_end   <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= 8'h00;
            wr_data <= 8'h00;
            busy    <= 1'b0;
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
`ifdef SPI_PKT_CHECKSUM_EN
            r_x     <= 8'h00;
            r_ck    <= 1'b0;
`endif
        end else begin
            wr_en   <= 1'b0;
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;
`ifdef SPI_PKT_CHECKSUM_EN
            if (rx_valid) r_x <= (r_state == S_IDLE) ? rx_data : w_x;
            if (rx_valid) r_ck <= (r_state == S_FILL) ? 1'b1 : (r_state == S_IDLE) ? 1'b0 : r_ck;
`endif
            case (r_state)
                S_IDLE: if (rx_valid) begin
                    r_fill  <= rx_data != OP_WRITE;
                    r_err   <= !w_op_ok;
                    r_hdr   <= 1'b0;
                    r_end   <= 1'b0;
                    r_state <= w_op_ok ? S_ADDR : S_DROP;
                end
                S_ADDR: if (rx_valid) begin
                    r_ptr   <= rx_data;
                    r_hdr   <= !r_fill;
                    r_state <= r_fill ? S_CNT : S_DATA;
                end
                S_DATA: if (rx_valid) begin
                    wr_en   <= 1'b1;
                    wr_addr <= r_ptr;
                    wr_data <= rx_data;
                    r_ptr   <= r_ptr + 8'd1;
                end
                S_CNT: if (rx_valid) begin
                    r_cnt   <= {rx_data == 8'h00, rx_data};
                    r_state <= S_VAL;
                end
                S_VAL: if (rx_valid) begin
                    r_val   <= rx_data;
                    r_hdr   <= 1'b1;
                    r_end   <= rx_end;
                    r_state <= S_FILL;
                end
                S_FILL: begin
                    if (rx_end) r_end <= 1'b1;
                    if (w_fill_err) r_err <= 1'b1;
                    if (r_cnt != 9'd0) begin
                        wr_en   <= 1'b1;
                        busy    <= 1'b1;
                        wr_addr <= r_ptr;
                        wr_data <= r_val;
                        r_ptr   <= r_ptr + 8'd1;
                        r_cnt   <= r_cnt - 9'd1;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_DROP;
                    end
                end
                S_DROP: ;
                default: r_state <= S_IDLE;
            endcase
            if (w_done) begin
                pkt_ok  <= !w_bad;
                pkt_err <= w_bad;
                r_state <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_spi_pkt_decoder.sv
// tb_spi_pkt_decoder: per-cycle vector table plus hand sequences for long fill, reset mid-fill and checksum.
`timescale 1ns/1ps
module tb_spi_pkt_decoder;
    logic       clk = 1'b0, rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0, rx_end = 1'b0;
    logic       wr_en, busy, pkt_ok, pkt_err;
    logic [7:0] wr_addr, wr_data;
    int         n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    spi_pkt_decoder dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_end(rx_end),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
        .pkt_ok(pkt_ok), .pkt_err(pkt_err)
    );

    typedef struct {
        logic v; logic [7:0] d; logic e;
        logic we; logic [7:0] wa; logic [7:0] wd; logic b; logic ok; logic er;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic v, input logic [7:0] d, input logic e, input logic we,
                                input logic [7:0] wa, input logic [7:0] wd, input logic b,
                                input logic ok, input logic er);
        vec_t t;
        t.v = v; t.d = d; t.e = e; t.we = we; t.wa = wa; t.wd = wd; t.b = b; t.ok = ok; t.er = er;
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // drive one cycle of inputs, sample outputs 1ns after the edge that consumed them
    task automatic cyc(input logic v, input logic [7:0] d, input logic e);
        @(negedge clk);
        rx_valid = v; rx_data = d; rx_end = e;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_end = 1'b0; rx_data = 8'h00;
    endtask

    always @(negedge clk)
        if (pkt_ok && pkt_err) begin
            n_err++;
            $display("FAIL excl: pkt_ok and pkt_err both high at %0t", $time);
        end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int nw, quiet;
        logic [7:0] la;
        bit done;
        #2;
        check("reset", 32'({wr_en, wr_addr, wr_data, busy, pkt_ok, pkt_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`ifndef SPI_PKT_CHECKSUM_EN
        //   v  d      e  we wa     wd     b  ok er
        add(1, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'hAA, 0, 1, 8'h10, 8'hAA, 0, 0, 0);
        add(1, 8'hBB, 0, 1, 8'h11, 8'hBB, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'hFF, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h11, 0, 1, 8'hFF, 8'h11, 0, 0, 0);
        add(1, 8'h22, 1, 1, 8'h00, 8'h22, 0, 1, 0);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h01, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h40, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0);
        add(1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h10, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(1, 8'h07, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h12, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'hF0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h03, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h5A, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 1, 8'hF0, 8'h5A, 1, 0, 0);
        add(0, 8'h00, 0, 1, 8'hF1, 8'h5A, 1, 0, 0);
        add(0, 8'h00, 0, 1, 8'hF2, 8'h5A, 1, 0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h30, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h77, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h99, 0, 1, 8'h30, 8'h77, 1, 0, 0);
        add(0, 8'h00, 1, 1, 8'h31, 8'h77, 1, 0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h50, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h01, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h66, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 0, 1, 8'h50, 8'h66, 1, 0, 0);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h12, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 0);
        add(1, 8'h55, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        add(1, 8'h66, 1, 0, 8'h00, 8'h00, 0, 0, 1);
        add(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].e);
            check($sformatf("row%0d ctl", i), 32'({wr_en, busy, pkt_ok, pkt_err}),
                  32'({tbl[i].we, tbl[i].b, tbl[i].ok, tbl[i].er}));
            if (tbl[i].we)
                check($sformatf("row%0d write", i), 32'({wr_addr, wr_data}), 32'({tbl[i].wa, tbl[i].wd}));
        end
        // count 00 means 256 writes, with the pointer wrapping
        cyc(1, 8'h02, 0); cyc(1, 8'hFE, 0); cyc(1, 8'h00, 0); cyc(1, 8'h11, 0);
        cyc(0, 8'h00, 1);
        check("fill256 first", 32'({wr_en, busy, wr_addr, wr_data}), 32'({2'b11, 16'hFE11}));
        nw = 0; la = 8'h00; done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            if (wr_en) begin nw++; la = wr_addr; end
            if (pkt_ok || pkt_err) done = 1;
            else cyc(0, 8'h00, 0);
        end
        check("fill256 count", 32'(nw), 32'd256);
        check("fill256 last addr", 32'(la), 32'h0FD);
        check("fill256 status", 32'({done, pkt_ok, pkt_err}), 32'b110);
        cyc(0, 8'h00, 0);
`else
        cyc(1, 8'h01, 0); cyc(1, 8'h20, 0);
        cyc(1, 8'h0F, 0);
        check("ck write1", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 16'h200F}));
        cyc(1, 8'h2E, 0);
        check("ck write2", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 16'h212E}));
        cyc(0, 8'h00, 1);
        check("ck good", 32'({pkt_ok, pkt_err}), 32'b10);
        cyc(1, 8'h01, 0); cyc(1, 8'h20, 0); cyc(1, 8'h0F, 0);
        cyc(1, 8'h2F, 0);
        check("ck bad write", 32'({wr_en, wr_addr, wr_data}), 32'({1'b1, 16'h212F}));
        cyc(0, 8'h00, 1);
        check("ck bad", 32'({pkt_ok, pkt_err}), 32'b01);
        cyc(0, 8'h00, 0);
`endif
        // reset on the second write of a 256-write fill
        cyc(1, 8'h02, 0); cyc(1, 8'h00, 0); cyc(1, 8'h00, 0); cyc(1, 8'h33, 0);
        cyc(0, 8'h00, 0);
        check("rstfill w1", 32'({wr_en, busy, wr_addr, wr_data}), 32'({2'b11, 16'h0033}));
        cyc(0, 8'h00, 0);
        check("rstfill w2", 32'({wr_en, busy, wr_addr, wr_data}), 32'({2'b11, 16'h0133}));
        rst = 1'b1;
        #1;
        check("rstfill abort", 32'({wr_en, busy, wr_addr, wr_data, pkt_ok, pkt_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        quiet = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 8'h00, k == 3);
            if (!wr_en && !busy && !pkt_ok && !pkt_err) quiet++;
        end
        check("rstfill quiet", 32'(quiet), 32'd6);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
